// File: rtl/flash_reader_pkg.sv
// flash_reader_pkg: shared constants and state encoding for the quad-SPI flash reader
package flash_reader_pkg;
    localparam logic [7:0] CMD_QIOR  = 8'hEB;
    localparam logic [7:0] MODE_BYTE = 8'h00;
    localparam int CMD_LEN  = 8;
    localparam int ADDR_LEN = 6;
    localparam int MODE_LEN = 2;
    localparam int DATA_LEN = 8;
    typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, DONE} state_t;
endpackage

// File: rtl/ahb_flash_reader.sv
// ahb_flash_reader: AHB-Lite read-only slave fetching words via quad-SPI Fast Read (0xEB) with a one-word buffer
module ahb_flash_reader
    import flash_reader_pkg::*;
#(
    parameter int DUMMY_CYCLES = 4,
    parameter int ADDR_BITS    = 24
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HSIZE,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    input  logic        inval,
    output logic        sck,
    output logic        ce_n,
    output logic [3:0]  dout,
    output logic        douten,
    input  logic [3:0]  din
);
    localparam int DW = $clog2(DUMMY_CYCLES + 1);
    state_t state, state_n;
    logic ph, buf_valid, fill_ok, rd_hit, active, idle, last, acc, hit, unused;
    logic [2:0] cnt, len_m1;
    logic [DW-1:0] dcnt;
    logic [31:0] sr, buf_data, word;
    logic [ADDR_BITS-3:0] buf_tag;
    assign unused = ^{HWDATA, HSIZE, HADDR[31:ADDR_BITS], HADDR[1:0], HTRANS[0]};
    assign word = {sr[7:0], sr[15:8], sr[23:16], sr[31:24]};
    always_comb begin
        idle   = state == IDLE || state == DONE;
        active = !idle;
        len_m1 = state == CMD ? 3'(CMD_LEN - 1) : state == ADDR ? 3'(ADDR_LEN - 1) :
                 state == MODE ? 3'(MODE_LEN - 1) : 3'(DATA_LEN - 1);
        last   = ph && (state == DUMMY ? dcnt == DW'(DUMMY_CYCLES - 1) : cnt == len_m1);
        // a word still in DONE is forwarded so a pipelined re-read of it hits
        hit    = buf_tag == HADDR[ADDR_BITS-1:2] && (buf_valid || (state == DONE && fill_ok && !inval));
        acc    = idle && HSEL && HREADY && HTRANS[1] && !HWRITE;
        state_n = idle ? (acc && !hit ? CMD : IDLE) :
                  !last ? state :
                  state == CMD ? ADDR : state == ADDR ? MODE : state == MODE ? DUMMY :
                  state == DUMMY ? DATA : DONE;
        dout   = state == CMD ? {3'b110, CMD_QIOR[3'd7 - cnt]} :
                 state == ADDR ? sr[31:28] :
                 state == MODE ? (cnt[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4]) : 4'h0;
        douten = state == CMD || state == ADDR || state == MODE;
        sck    = ph;
        ce_n   = idle;
        HREADYOUT = idle;
        HRDATA = state == DONE ? word : rd_hit ? buf_data : 32'h0;
    end
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ph        <= 1'b0;
            cnt       <= '0;
            dcnt      <= '0;
            sr        <= '0;
            buf_tag   <= '0;
            buf_data  <= '0;
            buf_valid <= 1'b0;
            fill_ok   <= 1'b0;
            rd_hit    <= 1'b0;
        end else begin
            ph     <= active ? ~ph : 1'b0;
            cnt    <= (!active || last) ? '0 : cnt + 3'(ph && state != DUMMY);
            dcnt   <= state == DUMMY ? dcnt + DW'(ph) : '0;
            rd_hit <= acc && hit;
            if (acc && !hit) begin
                sr        <= {HADDR[ADDR_BITS-1:2], 2'b00, 8'h00};
                buf_tag   <= HADDR[ADDR_BITS-1:2];
                buf_valid <= 1'b0;
                fill_ok   <= !inval;
            end else begin
                if (ph && state == ADDR) sr <= {sr[27:0], 4'h0};
                if (ph && state == DATA) sr <= {sr[27:0], din};
                if (state == DONE) buf_data <= word;
                buf_valid <= (buf_valid || (state == DONE && fill_ok)) && !inval;
                fill_ok   <= fill_ok && !inval;
            end
        end
    end
endmodule

// File: tb/tb_ahb_flash_reader.sv
// tb_ahb_flash_reader: directed and randomized checks of the flash reader against a behavioural flash and buffer model
module tb_ahb_flash_reader;
    localparam int D = 4;
    localparam int MISS_WAITS = 2 * (8 + 6 + 2 + D + 8);
    logic HCLK = 0, HRESETn = 0, HSEL = 0, HWRITE = 0, inval = 0;
    logic HREADYOUT, HREADY, sck, ce_n, douten;
    logic [31:0] HADDR = 0, HWDATA = 0, HRDATA;
    logic [1:0] HTRANS = 0;
    logic [2:0] HSIZE = 3'd2;
    logic [3:0] dout, din = 0;
    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    ahb_flash_reader #(.DUMMY_CYCLES(D), .ADDR_BITS(24)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HSIZE(HSIZE),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .inval(inval), .sck(sck), .ce_n(ce_n),
        .dout(dout), .douten(douten), .din(din)
    );

    // flash model: decodes the serial stream on each SCK rise and serves data nibbles from mem
    logic [7:0] mem [0:1023];
    int edges = 0, n_sel = 0, f_bad = 0;
    logic [7:0] f_cmd = 0, f_mode = 0;
    logic [23:0] f_addr = 0;
    logic sck_q = 0, ce_q = 1;
    always @(negedge HCLK) begin
        int j;
        logic [7:0] b;
        if (!ce_n && ce_q) begin
            edges = 0; f_cmd = 0; f_addr = 0; f_mode = 0; f_bad = 0; n_sel++;
        end
        if (!ce_n && sck && !sck_q) begin
            if (edges < 8) begin
                f_cmd = {f_cmd[6:0], dout[0]};
                if (dout[3:1] != 3'b110 || !douten) f_bad++;
            end else if (edges < 14) begin
                f_addr = {f_addr[19:0], dout};
                if (!douten) f_bad++;
            end else if (edges < 16) begin
                f_mode = {f_mode[3:0], dout};
                if (!douten) f_bad++;
            end else begin
                if (douten || (edges < 16 + D && dout != 0)) f_bad++;
            end
            if (edges >= 16 + D) begin
                j = edges - 16 - D;
                b = mem[(int'(f_addr) + j / 2) % 1024];
                din = (j % 2 == 0) ? b[7:4] : b[3:0];
            end
            edges++;
        end
        sck_q = sck;
        ce_q = ce_n;
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [31:0] a, input logic wr);
        HSEL = 1; HTRANS = 2'b10; HWRITE = wr; HADDR = a;
    endtask
    task automatic bus_idle();
        HSEL = 0; HTRANS = 2'b00; HWRITE = 0;
    endtask
    task automatic wait_data(output logic [31:0] d, output int w);
        w = 0;
        while (!HREADYOUT && w < 1000) begin
            @(posedge HCLK); #1;
            w++;
        end
        d = HRDATA;
    endtask
    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d, output int w);
        @(negedge HCLK); present(a, 0);
        @(posedge HCLK); #1; bus_idle();
        wait_data(d, w);
    endtask
    task automatic pulse_inval();
        @(negedge HCLK); inval = 1;
        @(negedge HCLK); inval = 0;
    endtask
    function automatic logic [31:0] mword(input logic [31:0] a);
        int base;
        base = int'(a[9:2]) * 4;
        return {mem[base + 3], mem[base + 2], mem[base + 1], mem[base]};
    endfunction

    initial begin
        logic [31:0] d, a;
        int w, n0;
        logic mv;
        logic [21:0] mt;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[256] = 8'h11; mem[257] = 8'h22; mem[258] = 8'h33; mem[259] = 8'h44;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_ce_n", ce_n, 1); chk("rst_sck", sck, 0); chk("rst_douten", douten, 0);
        chk("rst_dout", dout, 0); chk("rst_hreadyout", HREADYOUT, 1); chk("rst_hrdata", HRDATA, 0);
        @(negedge HCLK); HRESETn = 1;

        ahb_read(32'h100, d, w);
        chk("miss_waits", w, MISS_WAITS); chk("miss_data", d, 32'h44332211);
        chk("miss_cmd", f_cmd, 8'hEB); chk("miss_addr", f_addr, 24'h000100);
        chk("miss_mode", f_mode, 0); chk("miss_lines", f_bad, 0); chk("miss_sck_cycles", edges, 28);
        chk("done_ce_n", ce_n, 1);

        n0 = n_sel;
        ahb_read(32'h102, d, w);
        chk("hit_waits", w, 0); chk("hit_data", d, 32'h44332211);
        @(posedge HCLK); #1;
        chk("hit_no_flash", n_sel, n0); chk("idle_hrdata", HRDATA, 0); chk("hit_ce_n", ce_n, 1);

        pulse_inval();
        mem[256] = 8'hAA; mem[257] = 8'hBB; mem[258] = 8'hCC; mem[259] = 8'hDD;
        ahb_read(32'h100, d, w);
        chk("inval_waits", w, MISS_WAITS); chk("inval_data", d, 32'hDDCCBBAA);

        n0 = n_sel;
        @(negedge HCLK); present(32'h200, 1);
        @(posedge HCLK); #1; bus_idle();
        chk("write_ready", HREADYOUT, 1); chk("write_hrdata", HRDATA, 0);
        repeat (3) @(posedge HCLK);
        #1;
        chk("write_no_flash", n_sel, n0); chk("write_ce_n", ce_n, 1);
        ahb_read(32'h100, d, w);
        chk("post_write_hit_waits", w, 0); chk("post_write_hit_data", d, 32'hDDCCBBAA);

        pulse_inval();
        @(negedge HCLK); present(32'h100, 0);
        @(posedge HCLK); #1; present(32'h104, 0);
        wait_data(d, w);
        chk("pipe1_waits", w, MISS_WAITS); chk("pipe1_data", d, 32'hDDCCBBAA); chk("pipe_gap_hi", ce_n, 1);
        @(posedge HCLK); #1; bus_idle();
        chk("pipe_gap_lo", ce_n, 0);
        wait_data(d, w);
        chk("pipe2_waits", w, MISS_WAITS); chk("pipe2_data", d, mword(32'h104));

        @(negedge HCLK); present(32'h108, 0);
        @(posedge HCLK); #1; bus_idle();
        repeat (44) @(posedge HCLK);
        #1; HRESETn = 0; #1;
        chk("rst_mid_ce_n", ce_n, 1); chk("rst_mid_ready", HREADYOUT, 1); chk("rst_mid_hrdata", HRDATA, 0);
        @(negedge HCLK); HRESETn = 1;
        ahb_read(32'h108, d, w);
        chk("rst_mid_reread_waits", w, MISS_WAITS); chk("rst_mid_reread_data", d, mword(32'h108));

        mv = 1; mt = 22'h108 >> 2;
        for (int k = 0; k < 24; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                pulse_inval();
                mv = 0;
                mem[256 + $urandom_range(0, 15)] = 8'($urandom);
            end else if (r == 2) begin
                @(negedge HCLK); present(32'($urandom_range(0, 1023)), 1);
                @(posedge HCLK); #1; bus_idle();
                chk("rnd_write_ready", HREADYOUT, 1);
            end else begin
                a = 32'h100 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
                ahb_read(a, d, w);
                chk("rnd_waits", w, (mv && mt == a[23:2]) ? 0 : MISS_WAITS);
                chk("rnd_data", d, mword(a));
                mv = 1; mt = a[23:2];
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_flash_reader.md
# ahb_flash_reader

AHB-Lite read-only slave that fetches 32-bit words from an external quad-SPI NOR flash using the Fast Read Quad I/O command (0xEB), inserting wait states while the flash transaction runs. It is the hardware read path behind the flash writer's bypass mux: its `sck`/`ce_n`/`dout`/`douten` drive the writer's `fr_*` inputs, and `din` comes from the writer's `fr_din`. A one-word read buffer returns repeated reads of the same word without flash traffic.

## Interface
- `DUMMY_CYCLES`, 4: SCK cycles of dummy after the mode byte, ≥1.
- `ADDR_BITS`, 24: flash address width sent on the bus. Fixed at 24.
- `HCLK` in 1: clock.
- `HRESETn` in 1: reset, asynchronous, active-low.
- `HSEL`, `HADDR[31:0]`, `HTRANS[1:0]`, `HWRITE`, `HREADY`, `HWDATA[31:0]`, `HSIZE[2:0]` in: AHB-Lite slave inputs. `HWDATA` and `HSIZE` are unused.
- `HREADYOUT` out 1: low while a flash fetch is in progress.
- `HRDATA` out 32: read data, valid in the cycle `HREADYOUT` is high after a read.
- `inval` in 1: single-cycle pulse that invalidates the read buffer. Software pulses it after a flash write.
- `sck` out 1: flash clock, HCLK/2 while active.
- `ce_n` out 1: flash chip enable, active-low.
- `dout` out 4: IO[3:0] output data.
- `douten` out 1: output enable for all four IO lines, active-high.
- `din` in 4: IO[3:0] input data.

## Operation
- A read is accepted at a rising edge where `HSEL & HREADY & HTRANS[1] & ~HWRITE`. The word address is `HADDR[23:2]`, and byte address bits [1:0] are forced to 0.
- **Hit** (buffer valid, tag == `HADDR[23:2]`): zero-wait data phase, `HRDATA` = buffer, no flash activity.
- **Miss**: the FSM runs IDLE → CMD → ADDR → MODE → DUMMY → DATA → DONE → IDLE.
- Write transfers, and IDLE/BUSY transfers, get a zero-wait OKAY and are ignored. The response type is always OKAY.
- Every SCK cycle spans two HCLK cycles: a low phase (`sck`=0, new `dout` presented) followed by a high phase (`sck`=1).
  - `din` is captured at the HCLK edge that ends the high phase.
  - Shift and bit counters advance on that same edge.
- CMD: 8 SCK cycles, single-line.
  - `dout` = {1,1,0,cmd_bit}, MSB first, `douten`=1. IO3/IO2 are held high as HOLD#/WP#.
- ADDR: 6 SCK cycles, quad. The 24-bit address is sent high nibble first, `douten`=1.
- MODE: 2 SCK cycles, `dout`=4'h0, `douten`=1. The mode byte is 0x00, so there is no continuous-read mode.
- DUMMY: `DUMMY_CYCLES` SCK cycles, `douten`=0, `dout`=0.
- DATA: 8 SCK cycles, `douten`=0.
  - Nibbles arrive byte0-hi, byte0-lo, byte1-hi, and so on.
  - They are assembled little-endian: flash byte at address A+0 goes to `HRDATA[7:0]` and A+3 to `[31:24]`.
- DONE: one cycle.
  - `ce_n`=1 and `HREADYOUT`=1, with `HRDATA` = assembled word.
  - The buffer loads the word and tag and sets valid.
  - A pipelined transfer presented in this cycle is accepted normally.
- `inval` clears valid in any state. If `inval` coincides with DONE, valid stays 0, but the fetched word is still returned on `HRDATA`.
- `HSIZE` is ignored. The full word is always returned, and the master selects byte lanes.
- `HRDATA` = 0 in any cycle that is not a read data phase.

## Timing
- Reset values:
  - `ce_n`=1, `sck`=0, `douten`=0, `dout`=0.
  - `HREADYOUT`=1, `HRDATA`=0.
  - Buffer valid=0, FSM=IDLE.
- Reset asserted mid-transaction forces all of the above immediately (asynchronous). No partial word is buffered.
- Miss latency:
  - Address accepted at edge T0. `ce_n` falls in cycle 1.
  - `HREADYOUT`=0 in cycles 1…2·(24+`DUMMY_CYCLES`), which is 1…56 at default.
  - `HREADYOUT`=1 and data valid in cycle 57.
- Hit latency: 0 wait states.
- `ce_n` high time between back-to-back misses: at least 1 HCLK (the DONE cycle). Targets running HCLK ≤ 2·f_SCK,max are supported with no extra gap.
- Counters: bit counter 3 bits, dummy counter $clog2(`DUMMY_CYCLES`+1) bits. No wrap-around is possible within a phase.

## Structure
- A shared package `flash_reader_pkg` holds:
  - `CMD_QIOR` = 8'hEB and `MODE_BYTE` = 8'h00;
  - the state enum {IDLE, CMD, ADDR, MODE, DUMMY, DATA, DONE};
  - the phase lengths: CMD 8, ADDR 6, MODE 2, DATA 8.
- Single module, no sub-module. The FSM, 32-bit shift register, and 1-entry buffer (22-bit tag + 32-bit data + valid) all stay flat.

## Test plan
- **Reset:** reset asserted → all outputs at the reset values above; first read to 0x100 is a miss.
- **Miss:** flash model holds 11 22 33 44 at 0x000100; read 0x100 → IO0 carries 0xEB, address nibbles 0,0,0,1,0,0, then 2 mode cycles, 4 dummy cycles; 56 wait states; `HRDATA`=0x44332211.
- **Hit:** re-read 0x102 → 0 wait states, `HRDATA`=0x44332211, `ce_n` stays 1.
- **Invalidate:** pulse `inval`, then model changes 0x100 to AA BB CC DD; read 0x100 → full miss, `HRDATA`=0xDDCCBBAA.
- **Writes and pipelining:** write to 0x200 → `HREADYOUT`=1, no `ce_n` activity. Back-to-back reads 0x100 then 0x104, pipelined in DONE → `ce_n` high exactly 1 cycle, second word correct.
- **Reset mid-DATA:** reset asserted in the DATA phase → `ce_n`=1, `HREADYOUT`=1 immediately; next read of the same word is a miss.
